// File: rtl/remote_comm.sv
// rtl/remote_comm.sv - host-side command initiator: serializes cmd/data over a byte UART and awaits the response
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   snd_cmd, cmd, data      command request (accepted only when idle)
//   busy                    high while a command is in flight
//   cmd_cmplt               pulse: third byte transmitted
//   resp_rdy, resp          pulse + held response byte
//   timeout                 pulse: no response within 2^TMO_WIDTH-1 cycles
//   tx_data, trmt, tx_done  UART transmitter handshake
//   rx_rdy, rx_data         UART receiver byte available
//   clr_rx_rdy              clears rx_rdy at the receiver
module remote_comm #(
    parameter int TMO_WIDTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        snd_cmd,
    input  logic [7:0]  cmd,
    input  logic [15:0] data,
    output logic        busy,
    output logic        cmd_cmplt,
    output logic        resp_rdy,
    output logic [7:0]  resp,
    output logic        timeout,
    output logic [7:0]  tx_data,
    output logic        trmt,
    input  logic        tx_done,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TX1       = 3'd1,
        TX2       = 3'd2,
        TX3       = 3'd3,
        WAIT_RESP = 3'd4
    } state_t;

    localparam logic [TMO_WIDTH-1:0] TMO_MAX = '1;
    localparam logic [TMO_WIDTH-1:0] TMO_ONE = {{(TMO_WIDTH-1){1'b0}}, 1'b1};

    state_t                 state, state_nxt;
    logic [23:0]            shift_buf;
    logic [TMO_WIDTH-1:0]   timer;
    logic [TMO_WIDTH-1:0]   timer_inc;
    logic                   rx_new;
    logic                   accept, tx_adv, last_done, take, tmo_fire;

    // clr_rx_rdy is registered, so rx_rdy is still high for one cycle after
    // we clear it; masking with clr_rx_rdy keeps one byte from counting twice.
    assign rx_new    = rx_rdy && !clr_rx_rdy;
    assign timer_inc = timer + TMO_ONE;
    assign busy      = (state != IDLE);

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        tx_adv    = 1'b0;
        last_done = 1'b0;
        take      = 1'b0;
        tmo_fire  = 1'b0;
        case (state)
            IDLE: begin
                if (snd_cmd) begin
                    accept    = 1'b1;
                    state_nxt = TX1;
                end
            end
            TX1: begin
                if (tx_done) begin
                    tx_adv    = 1'b1;
                    state_nxt = TX2;
                end
            end
            TX2: begin
                if (tx_done) begin
                    tx_adv    = 1'b1;
                    state_nxt = TX3;
                end
            end
            TX3: begin
                if (tx_done) begin
                    last_done = 1'b1;
                    state_nxt = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                // A response arriving on the final timer cycle still wins.
                if (rx_new) begin
                    take      = 1'b1;
                    state_nxt = IDLE;
                end else if (timer_inc == TMO_MAX) begin
                    tmo_fire  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            shift_buf  <= 24'h0;
            timer      <= '0;
            tx_data    <= 8'h00;
            trmt       <= 1'b0;
            cmd_cmplt  <= 1'b0;
            resp_rdy   <= 1'b0;
            resp       <= 8'h00;
            timeout    <= 1'b0;
            clr_rx_rdy <= 1'b0;
        end else begin
            state      <= state_nxt;
            trmt       <= accept | tx_adv;
            cmd_cmplt  <= last_done;
            resp_rdy   <= take;
            timeout    <= tmo_fire;
            // Stale bytes outside WAIT_RESP are cleared and simply dropped.
            clr_rx_rdy <= rx_new;

            if (accept) begin
                shift_buf <= {cmd, data};
                tx_data   <= cmd;
            end else if (tx_adv) begin
                shift_buf <= {shift_buf[15:0], 8'h00};
                tx_data   <= shift_buf[15:8];
            end

            if (last_done)
                timer <= '0;
            else if (state == WAIT_RESP)
                timer <= timer_inc;

            if (take)
                resp <= rx_data;
        end
    end

endmodule

// File: tb/tb_remote_comm.sv
// tb/tb_remote_comm.sv - directed self-checking bench for remote_comm
module tb_remote_comm;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        snd_cmd = 1'b0;
    logic [7:0]  cmd = 8'h00;
    logic [15:0] data = 16'h0000;
    logic        busy, cmd_cmplt, resp_rdy, timeout, trmt, clr_rx_rdy;
    logic [7:0]  resp, tx_data;
    logic        tx_done = 1'b0;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;

    int pass_cnt = 0;
    int total_cnt = 0;

    remote_comm #(.TMO_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n), .snd_cmd(snd_cmd), .cmd(cmd), .data(data),
        .busy(busy), .cmd_cmplt(cmd_cmplt), .resp_rdy(resp_rdy), .resp(resp),
        .timeout(timeout), .tx_data(tx_data), .trmt(trmt), .tx_done(tx_done),
        .rx_rdy(rx_rdy), .rx_data(rx_data), .clr_rx_rdy(clr_rx_rdy)
    );

    always #5 clk = ~clk;

    // UART transmitter model: logs each byte, answers tx_done 10 cycles after trmt
    logic [7:0] tx_log[$];
    int         tx_cnt = 0;
    logic [7:0] tx_cur = 8'h00;
    int         stab_err = 0;
    int         resp_rdy_cnt = 0, timeout_cnt = 0, cmplt_cnt = 0, clr_cnt = 0;

    always @(negedge clk) begin
        if (!rst_n) begin
            tx_cnt  = 0;
            tx_done = 1'b0;
        end else begin
            tx_done = 1'b0;
            if (tx_cnt != 0) begin
                if (tx_data !== tx_cur || trmt) stab_err++;
                tx_cnt--;
                if (tx_cnt == 0) tx_done = 1'b1;
            end
            if (trmt) begin
                tx_log.push_back(tx_data);
                tx_cur = tx_data;
                tx_cnt = 10;
            end
            if (resp_rdy)   resp_rdy_cnt++;
            if (timeout)    timeout_cnt++;
            if (cmd_cmplt)  cmplt_cnt++;
            if (clr_rx_rdy) clr_cnt++;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] c, input logic [15:0] d);
        cmd = c; data = d; snd_cmd = 1'b1;
        step();
        snd_cmd = 1'b0;
    endtask

    task automatic wait_cmplt(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (cmd_cmplt) begin ok = 1'b1; break; end
        end
    endtask

    // Presents a byte at the receiver; returns in the cycle clr_rx_rdy is seen.
    task automatic deliver(input logic [7:0] b, output bit ok);
        rx_data = b; rx_rdy = 1'b1; ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (clr_rx_rdy) begin ok = 1'b1; break; end
        end
        rx_rdy = 1'b0;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic check_bytes(input string name, input int base,
                               input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        logic [23:0] got;
        got = 24'hxxxxxx;
        if (tx_log.size() >= base + 3) got = {tx_log[base], tx_log[base+1], tx_log[base+2]};
        total_cnt++;
        if (got !== {b0, b1, b2} || tx_log.size() != base + 3)
            $display("FAIL %s: bytes %h (count %0d) expected %h (count 3)", name, got, tx_log.size() - base, {b0, b1, b2});
        else pass_cnt++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        total_cnt++;
        if ({busy, cmd_cmplt, resp_rdy, timeout, trmt, clr_rx_rdy} !== 6'b0)
            $display("FAIL reset_flags: got %b expected 000000", {busy, cmd_cmplt, resp_rdy, timeout, trmt, clr_rx_rdy});
        else pass_cnt++;
        total_cnt++;
        if ({resp, tx_data} !== 16'h0000) $display("FAIL reset_data: got %h expected 0000", {resp, tx_data});
        else pass_cnt++;
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic();
        int base, r0; bit ok;
        base = tx_log.size(); r0 = resp_rdy_cnt;
        send(8'h02, 16'h1234);
        total_cnt++;
        if ({busy, trmt, tx_data} !== {2'b11, 8'h02}) $display("FAIL basic_first_byte: got %b expected 1100000010", {busy, trmt, tx_data});
        else pass_cnt++;
        wait_cmplt(ok);
        total_cnt++;
        if (!ok) $display("FAIL basic_cmplt: got no cmd_cmplt expected pulse");
        else pass_cnt++;
        deliver(8'hA5, ok);
        total_cnt++;
        if ({ok, resp_rdy, busy, resp} !== {3'b110, 8'hA5}) $display("FAIL basic_resp: got %b expected 11010100101", {ok, resp_rdy, busy, resp});
        else pass_cnt++;
        step(); step();
        check_bytes("basic_bytes", base, 8'h02, 8'h12, 8'h34);
        total_cnt++;
        if (resp_rdy_cnt - r0 != 1 || stab_err != 0) $display("FAIL basic_pulses: got resp_rdy %0d stab_err %0d expected 1 0", resp_rdy_cnt - r0, stab_err);
        else pass_cnt++;
    endtask

    task automatic test_batt();
        int base, r0; bit ok;
        base = tx_log.size(); r0 = resp_rdy_cnt;
        send(8'h01, 16'h0000);
        wait_cmplt(ok);
        deliver(8'hC3, ok);
        step(); step(); step();
        check_bytes("batt_bytes", base, 8'h01, 8'h00, 8'h00);
        total_cnt++;
        if (resp !== 8'hC3 || resp_rdy_cnt - r0 != 1) $display("FAIL batt_resp: got %h/%0d expected c3/1", resp, resp_rdy_cnt - r0);
        else pass_cnt++;
    endtask

    task automatic test_timeout();
        int n, r0, t0; bit ok;
        r0 = resp_rdy_cnt; t0 = timeout_cnt;
        send(8'h03, 16'h00AB);
        wait_cmplt(ok);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            step(); n++;
            if (timeout) break;
        end
        total_cnt++;
        if (!timeout || n != 15) $display("FAIL timeout_latency: got %0d cycles (timeout=%b) expected 15", n, timeout);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0 || resp !== 8'hC3) $display("FAIL timeout_state: got busy %b resp %h expected 0 c3", busy, resp);
        else pass_cnt++;
        step(); step();
        total_cnt++;
        if (timeout_cnt - t0 != 1 || resp_rdy_cnt != r0) $display("FAIL timeout_pulses: got %0d/%0d expected 1/0", timeout_cnt - t0, resp_rdy_cnt - r0);
        else pass_cnt++;
    endtask

    task automatic test_ignore_busy();
        int base, c0; bit ok;
        base = tx_log.size(); c0 = cmplt_cnt;
        send(8'h02, 16'h1234);
        for (int i = 0; i < 60 && tx_log.size() < base + 2; i++) step();
        send(8'h05, 16'hFFFF);
        wait_cmplt(ok);
        deliver(8'hA5, ok);
        step(); step(); step();
        check_bytes("ignore_bytes", base, 8'h02, 8'h12, 8'h34);
        total_cnt++;
        if (cmplt_cnt - c0 != 1 || busy !== 1'b0) $display("FAIL ignore_cmplt: got %0d busy %b expected 1 0", cmplt_cnt - c0, busy);
        else pass_cnt++;
    endtask

    task automatic test_stale();
        int c0, r0; bit ok;
        do_reset();
        c0 = clr_cnt; r0 = resp_rdy_cnt;
        send(8'h02, 16'h1234);
        deliver(8'h77, ok);
        step(); step();
        total_cnt++;
        if (!ok || clr_cnt - c0 != 1 || resp !== 8'h00 || resp_rdy_cnt != r0)
            $display("FAIL stale_drop: got clr %0d resp %h resp_rdy %0d expected 1 00 0", clr_cnt - c0, resp, resp_rdy_cnt - r0);
        else pass_cnt++;
        wait_cmplt(ok);
        deliver(8'hA5, ok);
        total_cnt++;
        if (resp !== 8'hA5 || resp_rdy !== 1'b1) $display("FAIL stale_then_resp: got %h/%b expected a5/1", resp, resp_rdy);
        else pass_cnt++;
        step(); step();
    endtask

    task automatic test_back_to_back();
        bit ok;
        send(8'h04, 16'h0102);
        wait_cmplt(ok);
        deliver(8'hA5, ok);
        // snd_cmd in the very cycle resp_rdy pulses
        send(8'h06, 16'h5566);
        total_cnt++;
        if ({busy, trmt, tx_data} !== {2'b11, 8'h06}) $display("FAIL b2b_accept: got %b expected 1100000110", {busy, trmt, tx_data});
        else pass_cnt++;
        wait_cmplt(ok);
        deliver(8'h3C, ok);
        step(); step();
        total_cnt++;
        if (resp !== 8'h3C || busy !== 1'b0) $display("FAIL b2b_resp: got %h busy %b expected 3c 0", resp, busy);
        else pass_cnt++;
    endtask

    task automatic test_midreset();
        int base; bit ok;
        base = tx_log.size();
        send(8'h02, 16'h1234);
        for (int i = 0; i < 60 && tx_log.size() < base + 2; i++) step();
        step();
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({busy, trmt, cmd_cmplt, tx_data, resp} !== 19'h0) $display("FAIL midreset_outputs: got %h expected 0", {busy, trmt, cmd_cmplt, tx_data, resp});
        else pass_cnt++;
        step(); step();
        rst_n = 1'b1;
        step(); step();
        base = tx_log.size();
        send(8'h07, 16'hBEEF);
        wait_cmplt(ok);
        deliver(8'hA5, ok);
        step(); step();
        check_bytes("midreset_restart", base, 8'h07, 8'hBE, 8'hEF);
        total_cnt++;
        if (resp !== 8'hA5 || stab_err != 0) $display("FAIL midreset_resp: got %h stab_err %0d expected a5 0", resp, stab_err);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_batt();
        test_timeout();
        test_ignore_busy();
        test_stale();
        test_back_to_back();
        test_midreset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
